// File: rtl/sbc_serial_subtractor_pkg.sv
// Shared ALU definitions for the nibble-serial subtract-with-borrow unit:
// nibble width, BCD correction constant and FSM state encoding.
package sbc_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BCD_ADJ = 4'h6;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef struct packed {
    logic [NIBBLE_W-1:0] bin;
    logic [NIBBLE_W-1:0] res;
    logic                borrow;
  } nib_step_t;

  // 5-bit nibble difference; bit NIBBLE_W is the borrow out.
  function automatic logic [NIBBLE_W:0] nib_sub(input logic [NIBBLE_W-1:0] a,
                                                 input logic [NIBBLE_W-1:0] b,
                                                 input logic                borrow);
    nib_sub = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, borrow};
  endfunction

endpackage

// File: rtl/sbc_nibble_step.sv
// Combinational 4-bit subtract with borrow and optional BCD -6 adjust.
// The adjust path exists only when SBC_DECIMAL_MODE_EN is defined.
module sbc_nibble_step
  import sbc_serial_subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                borrow_i,
  input  logic                dec_i,
  output logic [NIBBLE_W-1:0] bin_o,
  output logic [NIBBLE_W-1:0] res_o,
  output logic                borrow_o
);

  logic [NIBBLE_W:0] diff;

  assign diff     = nib_sub(a_i, b_i, borrow_i);
  assign bin_o    = diff[NIBBLE_W-1:0];
  assign borrow_o = diff[NIBBLE_W];

`ifdef SBC_DECIMAL_MODE_EN
  assign res_o = (dec_i && diff[NIBBLE_W]) ? (diff[NIBBLE_W-1:0] - BCD_ADJ)
                                            : diff[NIBBLE_W-1:0];
`else
  logic unused_dec;
  assign unused_dec = dec_i;
  assign res_o      = diff[NIBBLE_W-1:0];
`endif

endmodule

// File: rtl/sbc_serial_subtractor.sv
// Nibble-serial 6502 SBC unit: Result = DataA - DataB - (1 - CarryIn), LSB nibble
// first, Start/Done handshake. BCD adjust is built only with SBC_DECIMAL_MODE_EN.
module sbc_serial_subtractor
  import sbc_serial_subtractor_pkg::*;
#(
  parameter int NrOfBits = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Start,
  input  logic [NrOfBits-1:0] DataA,
  input  logic [NrOfBits-1:0] DataB,
  input  logic                CarryIn,
  input  logic                DecimalMode,
  output logic                Busy,
  output logic                Done,
  output logic [NrOfBits-1:0] Result,
  output logic                CarryOut,
  output logic                Overflow,
  output logic                Negative,
  output logic                Zero
);

  localparam int NrOfNibbles = NrOfBits / NIBBLE_W;
  localparam int IDX_W = (NrOfNibbles > 1) ? $clog2(NrOfNibbles) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NrOfNibbles - 1);

  state_t              state_q, state_d;
  logic [NrOfBits-1:0] a_q, a_d;
  logic [NrOfBits-1:0] b_q, b_d;
  logic [NrOfBits-1:0] res_q, res_d;
  logic [NrOfBits-1:0] bin_q, bin_d;
  logic                borrow_q, borrow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NrOfBits-1:0] result_q, result_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                neg_q, neg_d;
  logic                zero_q, zero_d;
  logic                step_dec;
  nib_step_t           step;

`ifdef SBC_DECIMAL_MODE_EN
  logic dec_q, dec_d;
  assign step_dec = dec_q;
`else
  logic unused_dec;
  assign unused_dec = DecimalMode;
  assign step_dec   = 1'b0;
`endif

  // Operands shift right each RUN cycle so the active nibble is always at [3:0].
  sbc_nibble_step u_step (
    .a_i      (a_q[NIBBLE_W-1:0]),
    .b_i      (b_q[NIBBLE_W-1:0]),
    .borrow_i (borrow_q),
    .dec_i    (step_dec),
    .bin_o    (step.bin),
    .res_o    (step.res),
    .borrow_o (step.borrow)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
`ifdef SBC_DECIMAL_MODE_EN
    dec_d    = dec_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d      = DataA;
          b_d      = DataB;
          borrow_d = ~CarryIn;
          idx_d    = '0;
          res_d    = '0;
          bin_d    = '0;
          busy_d   = 1'b1;
`ifdef SBC_DECIMAL_MODE_EN
          dec_d    = DecimalMode;
`endif
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> NIBBLE_W;
        b_d      = b_q >> NIBBLE_W;
        borrow_d = step.borrow;
        res_d    = (res_q >> NIBBLE_W) | (NrOfBits'(step.res) << (NrOfBits - NIBBLE_W));
        bin_d    = (bin_q >> NIBBLE_W) | (NrOfBits'(step.bin) << (NrOfBits - NIBBLE_W));
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Outputs load from the final-step next values so they are valid with Done.
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = res_d;
          carry_d  = ~step.borrow;
          ovf_d    = (a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1]) &
                     (a_q[NIBBLE_W-1] ^ step.bin[NIBBLE_W-1]);
          neg_d    = res_d[NrOfBits-1];
          zero_d   = (res_d == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SBC_DECIMAL_MODE_EN
      dec_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
`ifdef SBC_DECIMAL_MODE_EN
      dec_q    <= dec_d;
`endif
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign CarryOut = carry_q;
  assign Overflow = ovf_q;
  assign Negative = neg_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_sbc_serial_subtractor.sv
// Directed and randomized bench for sbc_serial_subtractor (8-bit), checked against
// an arithmetic reference model. Honours SBC_DECIMAL_MODE_EN like the design.
module tb_sbc_serial_subtractor;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       Start;
  logic [7:0] DataA;
  logic [7:0] DataB;
  logic       CarryIn;
  logic       DecimalMode;
  logic       Busy;
  logic       Done;
  logic [7:0] Result;
  logic       CarryOut;
  logic       Overflow;
  logic       Negative;
  logic       Zero;

  int checks = 0;
  int errors = 0;

  sbc_serial_subtractor #(.NrOfBits(8)) dut (
    .clock       (clk),
    .reset       (reset),
    .Start       (Start),
    .DataA       (DataA),
    .DataB       (DataB),
    .CarryIn     (CarryIn),
    .DecimalMode (DecimalMode),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result),
    .CarryOut    (CarryOut),
    .Overflow    (Overflow),
    .Negative    (Negative),
    .Zero        (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word integer arithmetic for binary/flags, digit loop for BCD.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic dec);
    exp_t       e;
    int         diff, sdiff, bor, da, db, d, dig;
    logic [7:0] r;
    diff  = int'(a) - int'(b) - (c ? 0 : 1);
    sdiff = int'($signed(a)) - int'($signed(b)) - (c ? 0 : 1);
    r     = 8'(diff);
`ifdef SBC_DECIMAL_MODE_EN
    if (dec) begin
      r   = '0;
      bor = c ? 0 : 1;
      for (int i = 0; i < 2; i++) begin
        da  = int'(a >> (4 * i)) & 15;
        db  = int'(b >> (4 * i)) & 15;
        d   = da - db - bor;
        bor = (d < 0) ? 1 : 0;
        dig = d & 15;
        if (bor == 1) dig = (dig - 6) & 15;
        r = r | 8'(dig << (4 * i));
      end
    end
`else
    if (dec) r = 8'(diff);
`endif
    e.r = r;
    e.c = (diff >= 0);
    e.v = (sdiff < -128) || (sdiff > 127);
    e.n = r[7];
    e.z = (r == 8'h00);
    return e;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic d, input exp_t e, input string tag);
    int   n;
    logic busy_ok;
    @(negedge clk);
    DataA = a; DataB = b; CarryIn = c; DecimalMode = d; Start = 1'b1;
    @(posedge clk); #1;
    Start   = 1'b0;
    n       = 1;
    busy_ok = 1'b1;
    while (Done !== 1'b1 && n < 10) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_busy_run"}, busy_ok, 1'b1);
    chk({tag, "_busy_at_done"}, Busy, 1'b0);
    chk({tag, "_result"}, Result, e.r);
    chk({tag, "_flags_cvnz"}, {CarryOut, Overflow, Negative, Zero}, {e.c, e.v, e.n, e.z});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, Done, 1'b0);
  endtask

  logic [7:0] a0, b0;
  logic       c0, d0;
  int         done_cnt, done_at;
  logic       hs_busy_ok;
  exp_t       got, e;

  initial begin
    reset = 1'b1; Start = 1'b0; DataA = '0; DataB = '0; CarryIn = 1'b0; DecimalMode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {Busy, Done, Result, CarryOut, Overflow, Negative, Zero}, '0);
    @(negedge clk);
    reset = 1'b0;

    run_op(8'h50, 8'hB0, 1'b1, 1'b0, exp_t'({8'hA0, 1'b0, 1'b1, 1'b1, 1'b0}), "bin_50_b0");
    run_op(8'h05, 8'h05, 1'b1, 1'b0, exp_t'({8'h00, 1'b1, 1'b0, 1'b0, 1'b1}), "bin_zero");
    run_op(8'h05, 8'h05, 1'b0, 1'b0, exp_t'({8'hFF, 1'b0, 1'b0, 1'b1, 1'b0}), "bin_borrow_in");
    run_op(8'h42, 8'h13, 1'b1, 1'b0, exp_t'({8'h2F, 1'b1, 1'b0, 1'b0, 1'b0}), "bin_42_13");
`ifdef SBC_DECIMAL_MODE_EN
    run_op(8'h42, 8'h13, 1'b1, 1'b1, exp_t'({8'h29, 1'b1, 1'b0, 1'b0, 1'b0}), "dec_42_13");
    run_op(8'h00, 8'h01, 1'b1, 1'b1, exp_t'({8'h99, 1'b0, 1'b0, 1'b1, 1'b0}), "dec_00_01");
`else
    run_op(8'h42, 8'h13, 1'b1, 1'b1, exp_t'({8'h2F, 1'b1, 1'b0, 1'b0, 1'b0}), "nodec_42_13");
    run_op(8'h00, 8'h01, 1'b1, 1'b1, exp_t'({8'hFF, 1'b0, 1'b0, 1'b1, 1'b0}), "nodec_00_01");
`endif

    for (int i = 0; i < 40; i++) begin
      a0 = 8'($urandom); b0 = 8'($urandom);
      c0 = 1'($urandom); d0 = 1'($urandom);
      run_op(a0, b0, c0, d0, model(a0, b0, c0, d0), $sformatf("rand%0d", i));
    end

    // Start held through busy and Done cycles; operand changes must be ignored.
    @(negedge clk);
    a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom); d0 = 1'($urandom);
    DataA = a0; DataB = b0; CarryIn = c0; DecimalMode = d0; Start = 1'b1;
    done_cnt = 0; done_at = 0; hs_busy_ok = 1'b1; got = '0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          got = {Result, CarryOut, Overflow, Negative, Zero};
        end
      end
      if (k <= 2 && Busy !== 1'b1) hs_busy_ok = 1'b0;
      if (k >= 3 && Busy !== 1'b0) hs_busy_ok = 1'b0;
      @(negedge clk);
      if (k <= 3) begin
        DataA = 8'($urandom); DataB = 8'($urandom);
        CarryIn = 1'($urandom); DecimalMode = 1'($urandom);
      end else begin
        Start = 1'b0;
      end
      @(posedge clk);
    end
    e = model(a0, b0, c0, d0);
    chk("hs_done_cycle", done_at, 3);
    chk("hs_done_count", done_cnt, 1);
    chk("hs_busy_window", hs_busy_ok, 1'b1);
    chk("hs_first_operands", got, e);

    // Asynchronous reset one cycle into an operation.
    @(negedge clk);
    DataA = 8'h50; DataB = 8'hB0; CarryIn = 1'b1; DecimalMode = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("rst_pre_busy", Busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outputs", {Busy, Done, Result, CarryOut, Overflow, Negative, Zero}, '0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    run_op(8'h05, 8'h05, 1'b0, 1'b0, exp_t'({8'hFF, 1'b0, 1'b0, 1'b1, 1'b0}), "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
